// File: rtl/start_sync_fifo_pkg.sv
// rtl/start_sync_fifo_pkg.sv - shared constants and helpers for start-token FIFOs
package start_sync_fifo_pkg;

  localparam int DEFAULT_DEPTH      = 3;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Occupancy needs one bit more than the read address to represent DEPTH itself.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/start_sync_fifo_srl.sv
// rtl/start_sync_fifo_srl.sv - write-enabled shift register with addressable read, no reset
module start_sync_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];
  logic [DATA_WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d = sr_q;
    if (we) begin
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  // Explicit decode keeps out-of-range addresses (never produced by the controller) harmless.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = sr_q[i];
      end
    end
  end

endmodule

// File: rtl/start_sync_srl_fifo.sv
// rtl/start_sync_srl_fifo.sv - start-token FIFO controller over SRL storage
// Optional if_count occupancy port: START_SYNC_FIFO_COUNT_EN.
module start_sync_srl_fifo
  import start_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef START_SYNC_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   if_count
`endif
);

  localparam int CW = count_width(ADDR_WIDTH);

  logic [CW-1:0]         count_q, count_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] srl_dout;

  always_comb begin
    push    = if_write & full_n_q;
    pop     = if_read & empty_n_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != CW'(DEPTH));
  end

  // Oldest entry sits at count-1; a simultaneous push/pop shifts it out and the next-oldest takes its slot.
  always_comb begin
    addr = '0;
    if (count_q != '0) begin
      addr = ADDR_WIDTH'(count_q - CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  start_sync_fifo_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .din  (if_din),
    .addr (addr),
    .dout (srl_dout)
  );

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  // Masking by the empty flag hides stale storage after reset.
  assign if_dout    = empty_n_q ? srl_dout : '0;

`ifdef START_SYNC_FIFO_COUNT_EN
  assign if_count = count_q;
`endif

endmodule

// File: tb/tb_start_sync_srl_fifo.sv
// tb/tb_start_sync_srl_fifo.sv - directed table-driven bench for start_sync_srl_fifo
module tb_start_sync_srl_fifo;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic       w;
    logic       r;
    logic       d;
    logic       en;
    logic       fn;
    logic       dout;
    logic [2:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [0:0] if_din = 1'b0;
  logic       if_write = 1'b0;
  logic       if_read = 1'b0;
  logic       if_full_n;
  logic       if_empty_n;
  logic [0:0] if_dout;
`ifdef START_SYNC_FIFO_COUNT_EN
  logic [2:0] if_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  start_sync_srl_fifo #(
    .DATA_WIDTH (1),
    .ADDR_WIDTH (2),
    .DEPTH      (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_din     (if_din),
    .if_write   (if_write),
    .if_full_n  (if_full_n),
    .if_read    (if_read),
    .if_empty_n (if_empty_n),
    .if_dout    (if_dout)
`ifdef START_SYNC_FIFO_COUNT_EN
    ,
    .if_count   (if_count)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic fn, input logic dout);
    chk({tag, " empty_n"}, {7'd0, if_empty_n}, {7'd0, en});
    chk({tag, " full_n"}, {7'd0, if_full_n}, {7'd0, fn});
    chk({tag, " dout"}, {7'd0, if_dout}, {7'd0, dout});
  endtask

  // Inputs are changed 1 time unit after the edge and outputs sampled 1 unit after the next edge.
  task automatic step(input logic w, input logic r, input logic d);
    if_write = w;
    if_read  = r;
    if_din   = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{w:H, r:L, d:H, en:H, fn:H, dout:H, cnt:3'd1};
    vecs[1]  = '{w:H, r:L, d:L, en:H, fn:H, dout:H, cnt:3'd2};
    vecs[2]  = '{w:H, r:L, d:H, en:H, fn:L, dout:H, cnt:3'd3};
    vecs[3]  = '{w:H, r:L, d:L, en:H, fn:L, dout:H, cnt:3'd3};
    vecs[4]  = '{w:L, r:H, d:L, en:H, fn:H, dout:L, cnt:3'd2};
    vecs[5]  = '{w:L, r:H, d:L, en:H, fn:H, dout:H, cnt:3'd1};
    vecs[6]  = '{w:L, r:H, d:L, en:L, fn:H, dout:L, cnt:3'd0};
    vecs[7]  = '{w:L, r:H, d:L, en:L, fn:H, dout:L, cnt:3'd0};
    vecs[8]  = '{w:H, r:H, d:L, en:H, fn:H, dout:L, cnt:3'd1};
    vecs[9]  = '{w:H, r:L, d:H, en:H, fn:H, dout:L, cnt:3'd2};
    vecs[10] = '{w:H, r:H, d:H, en:H, fn:H, dout:H, cnt:3'd2};
    vecs[11] = '{w:H, r:H, d:H, en:H, fn:H, dout:H, cnt:3'd2};
    vecs[12] = '{w:H, r:H, d:L, en:H, fn:H, dout:H, cnt:3'd2};
    vecs[13] = '{w:H, r:H, d:L, en:H, fn:H, dout:L, cnt:3'd2};
    vecs[14] = '{w:H, r:L, d:H, en:H, fn:L, dout:L, cnt:3'd3};
    vecs[15] = '{w:H, r:H, d:L, en:H, fn:H, dout:L, cnt:3'd2};
    vecs[16] = '{w:L, r:H, d:L, en:H, fn:H, dout:H, cnt:3'd1};
    vecs[17] = '{w:L, r:H, d:L, en:L, fn:H, dout:L, cnt:3'd0};

    // Asynchronous reset asserted mid-cycle, then idle.
    #3;
    reset_n = 1'b0;
    #1;
    chk_out("async reset", L, H, L);
`ifdef START_SYNC_FIFO_COUNT_EN
    chk("async reset count", {5'd0, if_count}, 8'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step(L, L, L);
      chk_out("reset idle", L, H, L);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(L, L, L);
      chk_out("post-reset idle", L, H, L);
    end

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].fn, vecs[i].dout);
`ifdef START_SYNC_FIFO_COUNT_EN
      chk($sformatf("vec%0d count", i), {5'd0, if_count}, {5'd0, vecs[i].cnt});
`endif
    end

    // Reset while holding two entries: flags must drop before the next edge.
    step(H, L, H);
    step(H, L, H);
    chk_out("pre-reset fill", H, H, H);
    step(L, L, L);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("mid-op reset", L, H, L);
`ifdef START_SYNC_FIFO_COUNT_EN
    chk("mid-op reset count", {5'd0, if_count}, 8'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("after release", L, H, L);
    step(L, H, L);
    chk_out("read after reset ignored", L, H, L);
    step(H, L, H);
    chk_out("write after reset", H, H, H);
    step(L, L, L);
    chk_out("hold after reset", H, H, H);
    step(L, H, L);
    chk_out("drain after reset", L, H, L);
    step(L, H, L);
    chk_out("no stale after drain", L, H, L);

`ifdef START_SYNC_FIFO_COUNT_EN
    // Count trace across push, push, push, pop.
    step(H, L, L);
    chk("trace count 1", {5'd0, if_count}, 8'd1);
    step(H, L, H);
    chk("trace count 2", {5'd0, if_count}, 8'd2);
    step(H, L, L);
    chk("trace count 3", {5'd0, if_count}, 8'd3);
    step(L, H, L);
    chk("trace count 2b", {5'd0, if_count}, 8'd2);
    chk("trace dout", {7'd0, if_dout}, 8'd1);
`endif

    step(L, L, L);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/start_sync_srl_fifo.md
Name: start_sync_srl_fifo

Overview:
- Controller-plus-storage FIFO that carries start tokens (or narrow data) from a producer dataflow process to a downstream PE process, e.g. the start chain feeding PE_i4xi4_pack_2x2.
- Storage is an SRL-style shift register with addressable read. This block owns the occupancy counter, read address and full/empty flags, and exposes HLS-style write/read handshakes.
- Sits directly upstream of the consuming PE's ap_start and directly downstream of the producer's start_out.

Parameters:
- DATA_WIDTH, 1, token/data width in bits.
- ADDR_WIDTH, 2, read-address width into the shift register; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 3, number of entries; legal range 2..2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_din  in  DATA_WIDTH  write data.
- if_write  in  1  write request.
- if_full_n  out  1  high = space available.
- if_read  in  1  read request.
- if_empty_n  out  1  high = data available.
- if_dout  out  DATA_WIDTH  head-of-FIFO data.
- if_count  out  ADDR_WIDTH+1  occupancy; present only with START_SYNC_FIFO_COUNT_EN.

Behaviour:
- Clocking and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset values: count=0, if_empty_n=0, if_full_n=1, if_dout=0, if_count=0. Shift-register contents are not reset.
- Accepted write (push) = if_write & if_full_n. Accepted read (pop) = if_read & if_empty_n. Requests outside these conditions are ignored with no state change.
- Push: shift register shifts and if_din enters slot 0.
- Read address: addr = count-1 when count>0, else 0. if_dout = SRL[addr] when if_empty_n=1, else forced 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: count unchanged; the shift still occurs, so the head stays at the same addr and now holds the next-oldest entry.
- Flags are registered from next-state count: if_empty_n_next = (count_next != 0); if_full_n_next = (count_next != DEPTH).
- Latency: a write into an empty FIFO raises if_empty_n on the following edge; if_dout is valid the same cycle if_empty_n rises. There is no fall-through.
- Full boundary (count=DEPTH):
  - if_write alone is ignored.
  - if_write with if_read: only the pop is accepted, count becomes DEPTH-1, if_full_n=1 next cycle.
- Empty boundary (count=0):
  - if_read alone is ignored.
  - if_write with if_read: only the push is accepted, count becomes 1.
- Ordering is strict FIFO; the order of a token sequence is never altered.
- Reset mid-operation: reset_n low immediately forces flags, count and if_dout to their reset values. Stale SRL contents are never visible afterwards because if_dout is masked by if_empty_n.
- No overflow or underflow is possible: count is always within 0..DEPTH.

Optional Feature:
- Macro START_SYNC_FIFO_COUNT_EN.
- Defined: port if_count is present and equals the registered count (0..DEPTH), updated on the same edge as the flags.
- Undefined: the port is absent. Behaviour is otherwise identical and the counter is still used internally.

Decomposition:
- Shared package start_sync_fifo_pkg holds:
  - a clog2 constant function;
  - default DEPTH/ADDR_WIDTH constants for start FIFOs;
  - a count-width localparam rule (ADDR_WIDTH+1).
- One sub-module: start_sync_fifo_srl. It is write-enabled, addressable shift storage with no reset. The controller instantiates it with we = push and addr = the computed addr.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> if_empty_n=0, if_full_n=1, if_dout=0 asynchronously; no change for 5 idle cycles.
- DEPTH=3; write 1,0,1 on consecutive cycles -> if_full_n=0 after the third edge. A 4th write of 0 is ignored. Reads then return 1,0,1, after which if_empty_n=0.
- Fill to 2 entries; assert if_write and if_read together for 4 cycles with data 1,1,0,0 -> count stays 2 and output order is preserved (first-in first).
- At count=3, assert write+read -> count becomes 2 and the new data is dropped. At count=0, assert write+read -> count becomes 1, the pushed data appears next cycle, and no read occurs.
- Assert reset_n low while count=2 -> flags revert immediately. After release, write 1 -> if_dout=1 with if_empty_n=1, and no stale value is ever exposed.
- With START_SYNC_FIFO_COUNT_EN: if_count tracks 0→1→2→3→2 across push, push, push, pop.
